// File: rtl/riscv_bus_pkg.sv
// Shared system-bus widths and the data-memory slave state encoding.
package riscv_bus_pkg;

  localparam int unsigned BUS_AW  = 32;
  localparam int unsigned BUS_DW  = 32;
  localparam int unsigned BUS_BEW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

endpackage

// File: rtl/riscv_sram_be.sv
// Single-port synchronous RAM with per-byte write enables and one-cycle read latency.
module riscv_sram_be
  import riscv_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS),
  parameter string       INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_addr,
  input  logic [BUS_DW-1:0]  i_wdata,
  input  logic [BUS_BEW-1:0] i_be,
  output logic [BUS_DW-1:0]  o_rdata
);

  logic [BUS_DW-1:0] r_mem [DEPTH_WORDS];
  logic [BUS_DW-1:0] r_rdata;

  // Byte-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BUS_BEW; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/riscv_data_mem.sv
// Data-memory bus slave: word reads / byte-enabled writes with fixed response latency.
module riscv_data_mem
  import riscv_bus_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [BUS_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned       WAIT_STATES = 0,
  parameter string             INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [BUS_AW-1:0]  addr_i,
  input  logic [BUS_DW-1:0]  wdata_i,
  input  logic [BUS_BEW-1:0] be_i,
  output logic [BUS_DW-1:0]  rdata_o,
  output logic               ack_o,
  output logic               error_o
);

  localparam int unsigned       IW        = $clog2(DEPTH_WORDS);
  localparam logic [BUS_AW:0]   MEM_BYTES = {1'b0, BUS_AW'(DEPTH_WORDS)} << 2;
  localparam logic [3:0]        WS_LOAD   = 4'(WAIT_STATES - 1);

  mem_state_t           r_state;
  logic [3:0]           r_cnt;
  logic                 r_we;
  logic [IW-1:0]        r_idx;
  logic [BUS_DW-1:0]    r_wdata;
  logic [BUS_BEW-1:0]   r_be;
  logic                 r_in_range;
  logic                 r_ack;
  logic                 r_err;
  logic                 r_rd_sel;

  logic [BUS_AW-1:0]    w_off;
  logic                 w_in_range;
  logic [IW-1:0]        w_idx;
  logic [IW-1:0]        w_ram_addr;
  logic                 w_ram_we;
  logic [BUS_DW-1:0]    w_ram_rdata;

  // Address decode of the incoming request (only consumed on acceptance).
  always_comb begin
    w_off      = addr_i - BASE_ADDR;
    w_in_range = (addr_i >= BASE_ADDR) && ({1'b0, w_off} < MEM_BYTES);
    w_idx      = IW'(w_off >> 2);
  end

  // Transaction FSM; response strobes are registered on entry to RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_in_range <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rd_sel   <= 1'b0;
    end else begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rd_sel <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_i) begin
            r_we       <= we_i;
            r_idx      <= w_idx;
            r_wdata    <= wdata_i;
            r_be       <= be_i;
            r_in_range <= w_in_range;
            if (WAIT_STATES > 0) begin
              r_state <= WAIT;
              r_cnt   <= WS_LOAD;
            end else begin
              r_state  <= RESP;
              r_ack    <= w_in_range;
              r_err    <= !w_in_range;
              r_rd_sel <= w_in_range && !we_i;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state  <= RESP;
            r_ack    <= r_in_range;
            r_err    <= !r_in_range;
            r_rd_sel <= r_in_range && !r_we;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // In IDLE the RAM is addressed straight from the bus so a zero-wait read lands in RESP;
  // otherwise the latched index keeps being read, so the last WAIT cycle's read lands in RESP.
  // Writes commit only at the end of RESP, so a reset before then drops them.
  always_comb begin
    w_ram_addr = (r_state == IDLE) ? w_idx : r_idx;
    w_ram_we   = (r_state == RESP) && r_we && r_in_range;
  end

  riscv_sram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (IW),
    .INIT_FILE   (INIT_FILE)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (w_ram_rdata)
  );

  assign rdata_o = r_rd_sel ? w_ram_rdata : '0;
  assign ack_o   = r_ack;
  assign error_o = r_err;

  // Master must not issue a new request until the previous one has been answered.
  a_req_while_busy: assert property (@(posedge clk) disable iff (!rstn)
    !(req_i && (r_state != IDLE)))
    else $warning("riscv_data_mem: req_i while busy was ignored");

  a_ack_err_excl: assert property (@(posedge clk) disable iff (!rstn) !(ack_o && error_o));

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed bench for riscv_data_mem: a zero-wait instance and a 3-wait-state instance.
module tb_riscv_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn0, rstn3;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        err   [2];

  int n_total = 0;
  int n_bad   = 0;

  riscv_data_mem #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_STATES (0),
    .INIT_FILE   ("")
  ) dut0 (
    .clk     (clk),
    .rstn    (rstn0),
    .req_i   (req[0]),
    .we_i    (we[0]),
    .addr_i  (addr[0]),
    .wdata_i (wdata[0]),
    .be_i    (be[0]),
    .rdata_o (rdata[0]),
    .ack_o   (ack[0]),
    .error_o (err[0])
  );

  riscv_data_mem #(
    .DEPTH_WORDS (64),
    .BASE_ADDR   (32'h0000_1000),
    .WAIT_STATES (3),
    .INIT_FILE   ("")
  ) dut3 (
    .clk     (clk),
    .rstn    (rstn3),
    .req_i   (req[1]),
    .we_i    (we[1]),
    .addr_i  (addr[1]),
    .wdata_i (wdata[1]),
    .be_i    (be[1]),
    .rdata_o (rdata[1]),
    .ack_o   (ack[1]),
    .error_o (err[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request pulse, then wait (bounded) for the response; lat = cycles after the req cycle.
  task automatic bus_xfer(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b,
                          output logic [31:0] rd, output logic ak, output logic er,
                          output int lat);
    rd = '0; ak = 1'b0; er = 1'b0; lat = -1;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    @(negedge clk);
    check_eq($sformatf("d%0d_no_resp_in_req_cycle@%h", d, a), 32'(ack[d] | err[d]), 32'd0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      req[d] = 1'b0;
      @(negedge clk);
      if (ack[d] || err[d]) begin
        rd = rdata[d]; ak = ack[d]; er = err[d]; lat = c;
        break;
      end
    end
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] b, input int exp_lat);
    logic [31:0] rd; logic ak, er; int lat;
    bus_xfer(d, 1'b1, a, wd, b, rd, ak, er, lat);
    check_eq($sformatf("d%0d_wr_lat@%h", d, a), 32'(lat), 32'(exp_lat));
    check_eq($sformatf("d%0d_wr_ack@%h", d, a), 32'(ak), 32'd1);
    check_eq($sformatf("d%0d_wr_err@%h", d, a), 32'(er), 32'd0);
    check_eq($sformatf("d%0d_wr_rdata0@%h", d, a), rd, 32'd0);
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] exp,
                         input int exp_lat);
    logic [31:0] rd; logic ak, er; int lat;
    bus_xfer(d, 1'b0, a, 32'h0, 4'h0, rd, ak, er, lat);
    check_eq($sformatf("d%0d_rd_lat@%h", d, a), 32'(lat), 32'(exp_lat));
    check_eq($sformatf("d%0d_rd_ack@%h", d, a), 32'(ak), 32'd1);
    check_eq($sformatf("d%0d_rd_data@%h", d, a), rd, exp);
  endtask

  task automatic do_err(input int d, input logic w, input logic [31:0] a, input int exp_lat);
    logic [31:0] rd; logic ak, er; int lat;
    bus_xfer(d, w, a, 32'hDEAD_DEAD, 4'hF, rd, ak, er, lat);
    check_eq($sformatf("d%0d_err_lat@%h", d, a), 32'(lat), 32'(exp_lat));
    check_eq($sformatf("d%0d_err_flag@%h", d, a), 32'(er), 32'd1);
    check_eq($sformatf("d%0d_err_noack@%h", d, a), 32'(ak), 32'd0);
    check_eq($sformatf("d%0d_err_rdata0@%h", d, a), rd, 32'd0);
  endtask

  logic [31:0] mdl [16];

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    rstn0 = 1'b0;
    rstn3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_reset_ack", d), 32'(ack[d]), 32'd0);
      check_eq($sformatf("d%0d_reset_err", d), 32'(err[d]), 32'd0);
      check_eq($sformatf("d%0d_reset_rdata", d), rdata[d], 32'd0);
    end
    @(posedge clk); #1;
    rstn0 = 1'b1;
    rstn3 = 1'b1;

    // Zero wait states: full write then read.
    do_write(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1);
    do_read (0, 32'h10, 32'hDEAD_BEEF, 1);

    // Byte lanes over a known word; empty byte-enable leaves it alone.
    do_write(0, 32'h20, 32'h1122_3344, 4'hF, 1);
    do_write(0, 32'h20, 32'h0000_00AA, 4'b0001, 1);
    do_write(0, 32'h20, 32'hBB00_0000, 4'b1000, 1);
    do_read (0, 32'h20, 32'hBB22_33AA, 1);
    do_write(0, 32'h20, 32'hFFFF_FFFF, 4'b0000, 1);
    do_read (0, 32'h22, 32'hBB22_33AA, 1);

    // Three wait states; pulses while busy must be ignored.
    do_write(1, 32'h1040, 32'h55AA_55AA, 4'hF, 4);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      req[1] = (c <= 3);
      we[1]  = 1'b1;
      be[1]  = 4'hF;
      if (c == 0) begin
        addr[1] = 32'h1004; wdata[1] = 32'h1111_1111;
      end else begin
        addr[1] = 32'h1040; wdata[1] = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      check_eq($sformatf("ws3_cyc%0d_ack", c), 32'(ack[1]), (c == 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("ws3_cyc%0d_err", c), 32'(err[1]), 32'd0);
    end
    do_read(1, 32'h1040, 32'h55AA_55AA, 4);
    do_read(1, 32'h1004, 32'h1111_1111, 4);

    // Out-of-range addresses around BASE_ADDR=0x1000, 64 words.
    do_write(1, 32'h1000, 32'hA5A5_A5A5, 4'hF, 4);
    do_write(1, 32'h10FC, 32'h5A5A_5A5A, 4'hF, 4);
    do_err(1, 1'b1, 32'h1100, 4);
    do_err(1, 1'b0, 32'h0FFC, 4);
    do_err(1, 1'b1, 32'h0FFC, 4);
    do_read(1, 32'h1000, 32'hA5A5_A5A5, 4);
    do_read(1, 32'h10FC, 32'h5A5A_5A5A, 4);

    // Reset in WAIT drops a pending write.
    do_write(1, 32'h1030, 32'h1234_5678, 4'hF, 4);
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h1030; wdata[1] = 32'hCAFE_F00D; be[1] = 4'hF;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    rstn3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("rst_mid_cyc%0d_resp", c), 32'(ack[1] | err[1]), 32'd0);
      check_eq($sformatf("rst_mid_cyc%0d_rdata", c), rdata[1], 32'd0);
      @(posedge clk); #1;
    end
    rstn3 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_cyc%0d_resp", c), 32'(ack[1] | err[1]), 32'd0);
    end
    do_read(1, 32'h1030, 32'h1234_5678, 4);

    // Back-to-back LSU-style traffic against a reference model.
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      do_write(0, 32'h100 + 32'(4 * i), mdl[i], 4'hF, 1);
    end
    for (int n = 0; n < 60; n++) begin
      int          i;
      logic [31:0] wd;
      logic [3:0]  b;
      i = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        b  = 4'($urandom_range(0, 15));
        do_write(0, 32'h100 + 32'(4 * i), wd, b, 1);
        for (int k = 0; k < 4; k++) begin
          if (b[k]) mdl[i][8*k +: 8] = wd[8*k +: 8];
        end
      end else begin
        do_read(0, 32'h100 + 32'(4 * i), mdl[i], 1);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
